// File: rtl/camera_pkg.sv
// camera_pkg: shared types and constants for the DVP camera emulator.
//   state_e    - frame sequencer states
//   pattern_e  - test pattern selector codes (PATTERN input)
//   BAR_RGB565 - eight-entry RGB565 colour-bar table, entry 0 = leftmost bar
package camera_pkg;

    localparam int unsigned H_W = 11;  // horizontal counter width (PCLK periods)
    localparam int unsigned V_W = 10;  // line-in-state counter width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PAT_COUNTER = 2'd0,
        PAT_RED     = 2'd1,
        PAT_BARS    = 2'd2,
        PAT_BLACK   = 2'd3
    } pattern_e;

    // Packed so entry [0] is the rightmost literal.
    localparam logic [7:0][15:0] BAR_RGB565 = {
        16'h0000,  // 7 black
        16'h001F,  // 6 blue
        16'hF800,  // 5 red
        16'hF81F,  // 4 magenta
        16'h07E0,  // 3 green
        16'h07FF,  // 2 cyan
        16'hFFE0,  // 1 yellow
        16'hFFFF   // 0 white
    };

endpackage

// File: rtl/dvp_pattern_rom.sv
// dvp_pattern_rom: combinational RGB565 test-pattern byte generator.
//   pattern_i  - pattern selector latched for the frame
//   row_i      - active line index, low 8 bits
//   col_i      - pixel column, low 8 bits
//   byte_sel_i - 0 = high byte (sent first), 1 = low byte
//   data_c_o   - pixel byte for this (row, column, byte)
module dvp_pattern_rom
    import camera_pkg::*;
(
    input  pattern_e   pattern_i,
    input  logic [7:0] row_i,
    input  logic [7:0] col_i,
    input  logic       byte_sel_i,
    output logic [7:0] data_c_o
);

    logic [15:0] bar_c;

    always_comb begin
        data_c_o = 8'h00;
        bar_c    = BAR_RGB565[col_i[7:5]];
        case (pattern_i)
            PAT_COUNTER: data_c_o = byte_sel_i ? col_i : row_i;
            PAT_RED:     data_c_o = byte_sel_i ? 8'h00 : 8'hF8;
            PAT_BARS:    data_c_o = byte_sel_i ? bar_c[7:0] : bar_c[15:8];
            default:     data_c_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/camera_dvp_emulator.sv
// camera_dvp_emulator: OV7670-style DVP transmitter emitting RGB565 test frames.
//   CLK, RST   - fabric clock, asynchronous active-high reset
//   START      - high streams frames back to back; low finishes the frame then idles
//   PATTERN    - test pattern code, sampled on entry to VSYNC
//   PCLK       - divided pixel clock (PCLK_HALF CLK cycles per half period)
//   VSYNC      - high during the VS_LINES sync lines of each frame
//   HREF       - high for the 2*H_ACTIVE byte slots of each active line
//   D          - pixel byte, high byte first, 0 outside HREF
//   FRAME_DONE - one-CLK pulse at the end of each frame
// VSYNC, HREF and D change only on the CLK edge where PCLK falls, so they are
// stable for PCLK_HALF CLK cycles ahead of every PCLK rising edge.
module camera_dvp_emulator
    import camera_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 160,
    parameter int unsigned H_BLANK   = 144,
    parameter int unsigned V_ACTIVE  = 120,
    parameter int unsigned VS_LINES  = 3,
    parameter int unsigned VBP_LINES = 17,
    parameter int unsigned VFP_LINES = 10,
    parameter int unsigned PCLK_HALF = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [1:0] PATTERN,
    output logic       PCLK,
    output logic       VSYNC,
    output logic       HREF,
    output logic [7:0] D,
    output logic       FRAME_DONE
);

    localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned HREF_LEN = 2 * H_ACTIVE;
    localparam int unsigned DIV_W    = $clog2(PCLK_HALF);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pclk_q, pclk_d;
    state_e           state_q, state_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [V_W-1:0]   v_q, v_d;
    pattern_e         pat_q, pat_d;
    logic             vsync_q, vsync_d;
    logic             href_q, href_d;
    logic [7:0]       data_q, data_d;
    logic             frame_done_q, frame_done_d;

    logic             fall_c;
    logic [V_W-1:0]   last_line_c;
    logic [7:0]       rom_byte_c;

    // Last line index of the current frame region.
    always_comb begin
        last_line_c = '0;
        case (state_q)
            ST_VSYNC:  last_line_c = V_W'(VS_LINES - 1);
            ST_VBACK:  last_line_c = V_W'(VBP_LINES - 1);
            ST_ACTIVE: last_line_c = V_W'(V_ACTIVE - 1);
            ST_VFRONT: last_line_c = V_W'(VFP_LINES - 1);
            default:   last_line_c = '0;
        endcase
    end

    // PCLK divider, h/v counters and frame sequencer; everything steps on a fall event.
    always_comb begin
        div_d        = div_q;
        pclk_d       = pclk_q;
        fall_c       = 1'b0;
        state_d      = state_q;
        h_d          = h_q;
        v_d          = v_q;
        pat_d        = pat_q;
        frame_done_d = 1'b0;

        if (div_q == DIV_W'(PCLK_HALF - 1)) begin
            div_d  = '0;
            pclk_d = ~pclk_q;
            fall_c = pclk_q;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (fall_c) begin
            if (state_q == ST_IDLE) begin
                if (START) begin
                    state_d = ST_VSYNC;
                    h_d     = '0;
                    v_d     = '0;
                    pat_d   = pattern_e'(PATTERN);
                end
            end else if (h_q == H_W'(LINE_LEN - 1)) begin
                h_d = '0;
                if (v_q == last_line_c) begin
                    v_d = '0;
                    case (state_q)
                        ST_VSYNC:  state_d = ST_VBACK;
                        ST_VBACK:  state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFRONT;
                        ST_VFRONT: begin
                            frame_done_d = 1'b1;
                            if (START) begin
                                state_d = ST_VSYNC;
                                pat_d   = pattern_e'(PATTERN);
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        default:   state_d = ST_IDLE;
                    endcase
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Byte for the slot the counters are about to enter.
    dvp_pattern_rom u_rom (
        .pattern_i  (pat_d),
        .row_i      (v_d[7:0]),
        .col_i      (h_d[8:1]),
        .byte_sel_i (h_d[0]),
        .data_c_o   (rom_byte_c)
    );

    // Video outputs are recomputed only on fall events so they hold across PCLK rise.
    always_comb begin
        vsync_d = vsync_q;
        href_d  = href_q;
        data_d  = data_q;
        if (fall_c) begin
            vsync_d = (state_d == ST_VSYNC);
            href_d  = (state_d == ST_ACTIVE) && (h_d < H_W'(HREF_LEN));
            data_d  = href_d ? rom_byte_c : 8'h00;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q        <= '0;
            pclk_q       <= 1'b0;
            state_q      <= ST_IDLE;
            h_q          <= '0;
            v_q          <= '0;
            pat_q        <= PAT_COUNTER;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            pclk_q       <= pclk_d;
            state_q      <= state_d;
            h_q          <= h_d;
            v_q          <= v_d;
            pat_q        <= pat_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign PCLK       = pclk_q;
    assign VSYNC      = vsync_q;
    assign HREF       = href_q;
    assign D          = data_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_camera_dvp_emulator.sv
// Bench for camera_dvp_emulator with a shrunken frame geometry.
module tb_camera_dvp_emulator;

    localparam int HA  = 160;
    localparam int HB  = 4;
    localparam int VA  = 6;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int VFP = 1;
    localparam int PH  = 2;
    localparam int LL  = 2 * HA + HB;              // 324 PCLK periods per line
    localparam int FL  = (VS + VBP + VA + VFP) * LL; // 3240 PCLK periods per frame

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [1:0] PATTERN;
    logic       PCLK, VSYNC, HREF, FRAME_DONE;
    logic [7:0] D;

    always #5 CLK = ~CLK;

    camera_dvp_emulator #(
        .H_ACTIVE (HA), .H_BLANK (HB), .V_ACTIVE (VA),
        .VS_LINES (VS), .VBP_LINES (VBP), .VFP_LINES (VFP), .PCLK_HALF (PH)
    ) dut (
        .CLK (CLK), .RST (RST), .START (START), .PATTERN (PATTERN),
        .PCLK (PCLK), .VSYNC (VSYNC), .HREF (HREF), .D (D), .FRAME_DONE (FRAME_DONE)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: frame position counted in PCLK periods since VSYNC entry.
    int       k     = 0;
    bit       m_act = 1'b0;
    int       m_p   = 0;
    bit [1:0] m_pat = 2'd0;
    bit       m_fd  = 1'b0;

    // PCLK-rise monitor state.
    int         prc        = 0;
    bit         vs_prev    = 1'b0;
    bit         href_prev  = 1'b0;
    int         vs_rises   = 0;
    int         vs_rise_t[$];
    int         vs_high    = 0;
    int         href_cnt   = 0;
    int         href_rises = 0;
    int         first_href_ofs = -1;
    int         col_cnt    = 0;
    int         row_len[VA];
    logic [7:0] cap[VA][2*HA];
    int         fd_w = 0, fd_last_w = 0, fd_pulses = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat_byte(input bit [1:0] pat, input int row, input int col, input int sel);
        logic [15:0] bars [8];
        logic [15:0] c;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        c = bars[(col / 32) % 8];
        case (pat)
            2'd0:    return (sel == 1) ? 8'(col) : 8'(row);
            2'd1:    return (sel == 1) ? 8'h00 : 8'hF8;
            2'd2:    return (sel == 1) ? c[7:0] : c[15:8];
            default: return 8'h00;
        endcase
    endfunction

    // {PCLK, VSYNC, HREF, D} the pins must show for the model position.
    function automatic logic [10:0] model_outs(input int kk, input bit act, input int p, input bit [1:0] pat);
        int line, h, row;
        logic vs, hr;
        logic [7:0] d;
        line = p / LL;
        h    = p % LL;
        row  = line - (VS + VBP);
        vs   = act && (line < VS);
        hr   = act && (row >= 0) && (row < VA) && (h < 2 * HA);
        d    = hr ? pat_byte(pat, row, h / 2, h % 2) : 8'h00;
        return {((kk / PH) % 2) == 1, vs, hr, d};
    endfunction

    task automatic wait_href_cnt(input int n, input int budget, input string name);
        int c = 0;
        while (href_cnt != n && c < budget) begin
            @(negedge CLK);
            c++;
        end
        check(name, href_cnt, n);
    endtask

    task automatic wait_fd(input int budget, input string name);
        int c = 0;
        do begin
            @(negedge CLK);
            c++;
        end while (!FRAME_DONE && c < budget);
        check(name, FRAME_DONE, 1);
    endtask

    // red=0: counter pattern row r (r, col); red=1: F8,00 pairs.
    task automatic check_row(input string name, input int r, input bit red);
        int bad = 0;
        int ex;
        for (int i = 0; i < 2 * HA; i++) begin
            if (red) ex = (i % 2 == 1) ? 0 : 'hF8;
            else     ex = (i % 2 == 1) ? i / 2 : r;
            if (cap[r][i] !== 8'(ex)) bad++;
        end
        check({name, " length"}, row_len[r], 2 * HA);
        check({name, " wrong bytes"}, bad, 0);
    endtask

    initial begin
        logic [10:0] e;
        int rise_a, rise_b, prev_pclk, vs0, hr0, prc0;

        RST = 1'b1; START = 1'b0; PATTERN = 2'd0;

        fork
            // Reference model step
            forever begin
                @(posedge CLK or posedge RST);
                if (RST) begin
                    k = 0; m_act = 1'b0; m_p = 0; m_pat = 2'd0; m_fd = 1'b0;
                end else begin
                    k++;
                    m_fd = 1'b0;
                    if (k % (2 * PH) == 0) begin
                        if (!m_act) begin
                            if (START) begin m_act = 1'b1; m_p = 0; m_pat = PATTERN; end
                        end else begin
                            m_p++;
                            if (m_p == FL) begin
                                m_fd = 1'b1; m_p = 0; m_pat = PATTERN; m_act = START;
                            end
                        end
                    end
                end
            end
            // Per-cycle compare against the model, plus FRAME_DONE pulse width
            forever begin
                @(negedge CLK);
                e = model_outs(k, m_act, m_p, m_pat);
                check("pclk", PCLK, e[10]);
                check("vsync", VSYNC, e[9]);
                check("href", HREF, e[8]);
                check("d", D, e[7:0]);
                check("frame_done", FRAME_DONE, m_fd);
                if (FRAME_DONE) fd_w++;
                else if (fd_w > 0) begin fd_last_w = fd_w; fd_pulses++; fd_w = 0; end
            end
            // Capture as a DVP receiver would, on PCLK rising edges
            forever begin
                @(posedge PCLK);
                prc++;
                if (VSYNC && !vs_prev) begin
                    vs_rises++; vs_rise_t.push_back(prc);
                    vs_high = 0; href_cnt = 0; first_href_ofs = -1;
                    for (int r = 0; r < VA; r++) row_len[r] = 0;
                end
                if (VSYNC) vs_high++;
                if (HREF && !href_prev) begin
                    href_cnt++; href_rises++; col_cnt = 0;
                    if (first_href_ofs < 0 && vs_rise_t.size() > 0) first_href_ofs = prc - vs_rise_t[$];
                end
                if (HREF) begin
                    if (href_cnt >= 1 && href_cnt <= VA && col_cnt < 2 * HA) cap[href_cnt-1][col_cnt] = D;
                    col_cnt++;
                    if (href_cnt >= 1 && href_cnt <= VA) row_len[href_cnt-1] = col_cnt;
                end
                vs_prev = VSYNC; href_prev = HREF;
            end
        join_none

        // Reset values
        repeat (3) @(negedge CLK);
        check("reset pclk", PCLK, 0);
        check("reset vsync", VSYNC, 0);
        check("reset href", HREF, 0);
        check("reset d", D, 0);
        check("reset frame_done", FRAME_DONE, 0);

        // PCLK period, START low
        RST = 1'b0;
        rise_a = -1; rise_b = -1; prev_pclk = PCLK;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (PCLK && !prev_pclk) begin
                if (rise_a < 0) rise_a = c; else if (rise_b < 0) rise_b = c;
            end
            prev_pclk = PCLK;
        end
        check("pclk period clk", rise_b - rise_a, 4);
        check("idle no vsync", vs_rises, 0);

        // Frame 1: pattern 0, switched to 1 mid-frame
        START = 1'b1;
        wait_href_cnt(2, 5 * LL * PH * 2, "f1 reach line 1");
        PATTERN = 2'd1;
        wait_fd(FL * PH * 2 + 100, "f1 frame_done");
        check("f1 vsync pclk periods", vs_high, VS * LL);
        check("f1 first href offset", first_href_ofs, (VS + VBP) * LL);
        check("f1 href pulses", href_cnt, VA);
        check_row("f1 row5", 5, 1'b0);
        check("f1 row5 byte0", cap[5][0], 8'h05);
        check("f1 row5 last", cap[5][2*HA-1], 8'h9F);

        // Frame 2: pattern 1, switch to 2 mid-frame
        wait_href_cnt(1, 5 * LL * PH * 2, "f2 reach line 0");
        PATTERN = 2'd2;
        wait_fd(FL * PH * 2 + 100, "f2 frame_done");
        check_row("f2 row0 red", 0, 1'b1);
        check_row("f2 row5 red", 5, 1'b1);
        check("frame period", vs_rise_t[1] - vs_rise_t[0], 3240);

        // Frame 3: colour bars
        wait_href_cnt(1, 5 * LL * PH * 2, "f3 reach line 0");
        PATTERN = 2'd0;
        wait_fd(FL * PH * 2 + 100, "f3 frame_done");
        check("bars col0 b1", cap[0][0], 8'hFF);
        check("bars col0 b2", cap[0][1], 8'hFF);
        check("bars col32 b1", cap[0][64], 8'hFF);
        check("bars col32 b2", cap[0][65], 8'hE0);
        check("bars col64 b1", cap[3][128], 8'h07);
        check("bars col64 b2", cap[3][129], 8'hFF);
        check("bars col128 b1", cap[0][256], 8'hF8);
        check("bars col128 b2", cap[0][257], 8'h1F);
        check("bars col159 b1", cap[5][318], 8'hF8);
        check("bars col159 b2", cap[5][319], 8'h1F);
        check("bars row len", row_len[2], 2 * HA);

        // Frame 4: START dropped during active line 3
        wait_href_cnt(4, 8 * LL * PH * 2, "f4 reach line 3");
        START = 1'b0;
        wait_fd(FL * PH * 2 + 100, "f4 frame_done");
        check("f4 href pulses", href_cnt, VA);
        check_row("f4 row5", 5, 1'b0);
        vs0 = vs_rises; hr0 = href_rises; prc0 = prc;
        repeat (2 * LL * PH * 2) @(negedge CLK);
        check("idle vsync rises", vs_rises - vs0, 0);
        check("idle href rises", href_rises - hr0, 0);
        check("idle pclk rises", prc - prc0, 2 * LL);
        check("frame_done pulses", fd_pulses, 4);
        check("frame_done width", fd_last_w, 1);
        check("idle vsync level", VSYNC, 0);

        // Asynchronous reset during HREF
        START = 1'b1;
        begin
            int c = 0;
            while (!(HREF && PCLK && D != 8'h00) && c < 6 * LL * PH * 2) begin
                @(negedge CLK);
                c++;
            end
        end
        check("pre-reset href", HREF, 1);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("async pclk", PCLK, 0);
        check("async vsync", VSYNC, 0);
        check("async href", HREF, 0);
        check("async d", D, 0);
        @(negedge CLK);
        RST = 1'b0;
        START = 1'b0;
        vs0 = vs_rises; hr0 = href_rises;
        repeat (2 * LL * PH * 2) @(negedge CLK);
        check("post-reset vsync rises", vs_rises - vs0, 0);
        check("post-reset href rises", href_rises - hr0, 0);
        START = 1'b1;
        begin
            int c = 0;
            while (!VSYNC && c < 16) begin
                @(negedge CLK);
                c++;
            end
        end
        check("restart vsync", VSYNC, 1);
        repeat (10) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
